// File: rtl/spi_master_if.sv
// spi_master_if: host handshake plus SPI pins of the register-access initiator.
// The master modport is the initiator's view; slave is the host/target side.
interface spi_master_if #(
    parameter int ADDRSZ  = 7,
    parameter int PAYLOAD = 8
);
    logic               start;
    logic               rw;
    logic [ADDRSZ-1:0]  addr;
    logic [PAYLOAD-1:0] wdata;
    logic               busy;
    logic               done;
    logic [PAYLOAD-1:0] rdata;
    logic               rdata_valid;
    logic               SCLK;
    logic               SSB;
    logic               MOSI;
    logic               MISO;

    modport master (
        input  start, rw, addr, wdata, MISO,
        output busy, done, rdata, rdata_valid, SCLK, SSB, MOSI
    );

    modport slave (
        output start, rw, addr, wdata, MISO,
        input  busy, done, rdata, rdata_valid, SCLK, SSB, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator for the {rw, addr, data} register-access frame.
// SSB/SCLK/MOSI are generated from clk with programmable setup, half-period, hold and idle gap.
module spi_master #(
    parameter int PKTSZ    = 16,
    parameter int ADDRSZ   = 7,
    parameter int PAYLOAD  = 8,
    parameter int CLKDIV   = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int IDLE_GAP = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    spi_master_if.master bus
);
    localparam int MAX_A = (CLKDIV > CS_SETUP) ? CLKDIV : CS_SETUP;
    localparam int MAX_B = (CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP;
    localparam int PW    = $clog2((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1;
    localparam int BW    = $clog2(PKTSZ) + 1;
    localparam logic [PW-1:0] SETUP_L = PW'(CS_SETUP - 1);
    localparam logic [PW-1:0] DIV_L   = PW'(CLKDIV - 1);
    localparam logic [PW-1:0] HOLD_L  = PW'(CS_HOLD - 1);
    localparam logic [PW-1:0] GAP_L   = PW'(IDLE_GAP - 1);
    localparam logic [BW-1:0] PKT_B   = BW'(PKTSZ);
    localparam logic [BW-1:0] CAP_B   = BW'(ADDRSZ + 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_e;

    state_e             state_q;
    logic [PW-1:0]      ph_q;
    logic [BW-1:0]      bit_q;
    logic [PKTSZ-1:0]   tx_q;
    logic [PAYLOAD-1:0] rx_q;
    logic [PAYLOAD-1:0] rdata_q;
    logic [1:0]         miso_q;
    logic               rw_q;
    logic               sclk_q;
    logic               ssb_q;
    logic               mosi_q;
    logic               busy_q;
    logic               done_q;
    logic               rdv_q;
    logic               ph_end;

    always_comb begin
        ph_end = (state_q == SETUP) ? (ph_q == SETUP_L) :
                 (state_q == HOLD)  ? (ph_q == HOLD_L)  :
                 (state_q == GAP)   ? (ph_q == GAP_L)   : (ph_q == DIV_L);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            miso_q  <= '0;
            rw_q    <= 1'b0;
            sclk_q  <= 1'b0;
            ssb_q   <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            miso_q <= {miso_q[0], bus.MISO};
            done_q <= 1'b0;
            rdv_q  <= 1'b0;
            ph_q   <= ph_end ? '0 : ph_q + 1'b1;
            case (state_q)
                IDLE: begin
                    ph_q <= '0;
                    if (bus.start) begin
                        // first bit goes out directly; tx_q holds the remaining bits
                        tx_q    <= {bus.addr, bus.wdata, 1'b0};
                        mosi_q  <= bus.rw;
                        rw_q    <= bus.rw;
                        ssb_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        bit_q   <= '0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (ph_end) begin
                        sclk_q  <= 1'b1;
                        bit_q   <= BW'(1);
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    if (ph_end) begin
                        sclk_q  <= 1'b0;
                        mosi_q  <= tx_q[PKTSZ-1];
                        tx_q    <= {tx_q[PKTSZ-2:0], 1'b0};
                        state_q <= LOW;
                    end
                end
                LOW: begin
                    if (ph_end) begin
                        if (bit_q < PKT_B) begin
                            sclk_q  <= 1'b1;
                            bit_q   <= bit_q + 1'b1;
                            state_q <= HIGH;
                            // rising edge bit_q+1 falls in the data field
                            if (rw_q && bit_q >= CAP_B)
                                rx_q <= {rx_q[PAYLOAD-2:0], miso_q[1]};
                        end else begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ph_end) begin
                        ssb_q   <= 1'b1;
                        done_q  <= 1'b1;
                        rdv_q   <= rw_q;
                        state_q <= GAP;
                        if (rw_q)
                            rdata_q <= rx_q;
                    end
                end
                GAP: begin
                    if (ph_end) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.SCLK        = sclk_q;
    assign bus.SSB         = ssb_q;
    assign bus.MOSI        = mosi_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdv_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed tests of the SPI initiator against a mode-0 register target model.
// Two instances: default timing and a slower CLKDIV=8 / CS_SETUP=6 variant, one active at a time.
module tb_spi_master;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sel = 1'b0;
    logic       st = 1'b0;
    logic       t_rw = 1'b0;
    logic [6:0] t_addr = '0;
    logic [7:0] t_wdata = '0;
    logic       miso_t = 1'b0;
    int         checks = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    spi_master_if ifc ();
    spi_master_if ifv ();

    spi_master u_dut (.clk(clk), .reset_n(reset_n), .bus(ifc));
    spi_master #(.CLKDIV(8), .CS_SETUP(6)) u_var (.clk(clk), .reset_n(reset_n), .bus(ifv));

    assign ifc.start = st && !sel;
    assign ifv.start = st && sel;
    assign ifc.rw    = t_rw;
    assign ifv.rw    = t_rw;
    assign ifc.addr  = t_addr;
    assign ifv.addr  = t_addr;
    assign ifc.wdata = t_wdata;
    assign ifv.wdata = t_wdata;
    assign ifc.MISO  = miso_t;
    assign ifv.MISO  = miso_t;

    logic       m_sclk, m_ssb, m_mosi, m_busy, m_done, m_rdv;
    logic [7:0] m_rdata;
    assign m_sclk  = sel ? ifv.SCLK : ifc.SCLK;
    assign m_ssb   = sel ? ifv.SSB : ifc.SSB;
    assign m_mosi  = sel ? ifv.MOSI : ifc.MOSI;
    assign m_busy  = sel ? ifv.busy : ifc.busy;
    assign m_done  = sel ? ifv.done : ifc.done;
    assign m_rdv   = sel ? ifv.rdata_valid : ifc.rdata_valid;
    assign m_rdata = sel ? ifv.rdata : ifc.rdata;

    // target model: samples MOSI on SCLK rise, drives read data after falling edge 8
    logic        sclk_p = 1'b0;
    logic        ssb_p = 1'b1;
    int          tbits = 0;
    logic [15:0] tsr = '0;
    logic [6:0]  reg_addr = '0;
    logic [7:0]  rx_d = '0;
    logic        rxdv = 1'b0;
    logic [7:0]  rd_byte = '0;

    always @(negedge clk) begin
        sclk_p <= m_sclk;
        ssb_p  <= m_ssb;
        if (!m_ssb && ssb_p)
            rxdv <= 1'b0;
        if (m_ssb) begin
            tbits <= 0;
        end else if (m_sclk && !sclk_p) begin
            tsr   <= {tsr[14:0], m_mosi};
            tbits <= tbits + 1;
            if (tbits == 15) begin
                reg_addr <= tsr[13:7];
                rx_d     <= {tsr[6:0], m_mosi};
                rxdv     <= !tsr[14];
            end
        end else if (!m_sclk && sclk_p && tbits >= 8 && tbits < 16) begin
            miso_t <= rd_byte[3'(15 - tbits)];
        end
    end

    int         ssb_lo, busy_hi, dn, rv, rv_bad, rise1, half, tmo;
    logic [7:0] rd_at;

    task automatic frame(input logic r, input logic [6:0] a, input logic [7:0] d, input bit poke);
        logic pr;
        ssb_lo = 0; busy_hi = 0; dn = 0; rv = 0; rv_bad = 0; rise1 = -1; half = -1; tmo = 1;
        rd_at = 'x; pr = 1'b0;
        @(negedge clk);
        st = 1'b1; t_rw = r; t_addr = a; t_wdata = d;
        @(negedge clk);
        st = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (!m_busy) begin
                tmo = 0;
                break;
            end
            busy_hi++;
            if (!m_ssb) ssb_lo++;
            if (m_done) begin
                dn++;
                rd_at = m_rdata;
            end
            if (m_rdv) begin
                rv++;
                if (!m_done) rv_bad++;
            end
            if (m_sclk && !pr && rise1 < 0) rise1 = n;
            if (!m_sclk && pr && half < 0) half = n - rise1;
            pr = m_sclk;
            if (poke && n == 50) begin
                st = 1'b1; t_rw = ~r; t_addr = ~a; t_wdata = ~d;
            end
            if (poke && n == 51) st = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ifc.SSB !== 1'b1) $display("FAIL reset_ssb: got %b want 1", ifc.SSB); else passed++;
        checks++; if (ifc.SCLK !== 1'b0) $display("FAIL reset_sclk: got %b want 0", ifc.SCLK); else passed++;
        checks++; if (ifc.MOSI !== 1'b0) $display("FAIL reset_mosi: got %b want 0", ifc.MOSI); else passed++;
        checks++; if (ifc.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", ifc.busy); else passed++;
        checks++; if (ifc.done !== 1'b0 || ifc.rdata_valid !== 1'b0)
            $display("FAIL reset_pulses: done=%b rdv=%b want 0", ifc.done, ifc.rdata_valid); else passed++;
        checks++; if (ifc.rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", ifc.rdata); else passed++;
        checks++; if (ifv.SSB !== 1'b1 || ifv.busy !== 1'b0)
            $display("FAIL reset_var: ssb=%b busy=%b want 1/0", ifv.SSB, ifv.busy); else passed++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        sel = 1'b0;
        frame(1'b0, 7'h15, 8'h3C, 1'b0);
        checks++; if (tmo != 0) $display("FAIL write_timeout: busy never fell"); else passed++;
        checks++; if (tsr !== 16'h153C) $display("FAIL write_mosi: got %h want 153c", tsr); else passed++;
        checks++; if (ssb_lo != 136) $display("FAIL write_ssb_low: got %0d want 136", ssb_lo); else passed++;
        checks++; if (busy_hi != 140) $display("FAIL write_busy: got %0d want 140", busy_hi); else passed++;
        checks++; if (dn != 1) $display("FAIL write_done: got %0d pulses want 1", dn); else passed++;
        checks++; if (rv != 0) $display("FAIL write_rdv: got %0d pulses want 0", rv); else passed++;
        checks++; if (rise1 != 4) $display("FAIL write_first_rise: got %0d want 4", rise1); else passed++;
        checks++; if (half != 4) $display("FAIL write_half: got %0d want 4", half); else passed++;
        checks++; if (reg_addr !== 7'h15) $display("FAIL write_reg_addr: got %h want 15", reg_addr); else passed++;
        checks++; if (rx_d !== 8'h3C) $display("FAIL write_rx_d: got %h want 3c", rx_d); else passed++;
        checks++; if (rxdv !== 1'b1) $display("FAIL write_rxdv: got %b want 1", rxdv); else passed++;
        checks++; if (ifc.rdata !== 8'h00) $display("FAIL write_rdata: got %h want 00", ifc.rdata); else passed++;
    endtask

    task automatic test_read;
        sel = 1'b0;
        rd_byte = 8'hA5;
        frame(1'b1, 7'h05, 8'h00, 1'b0);
        checks++; if (tsr[15:8] !== 8'h85) $display("FAIL read_header: got %h want 85", tsr[15:8]); else passed++;
        checks++; if (rd_at !== 8'hA5) $display("FAIL read_rdata: got %h want a5", rd_at); else passed++;
        checks++; if (rv != 1 || rv_bad != 0)
            $display("FAIL read_rdv: got %0d pulses, %0d outside done, want 1/0", rv, rv_bad); else passed++;
        checks++; if (dn != 1) $display("FAIL read_done: got %0d want 1", dn); else passed++;
        checks++; if (rxdv !== 1'b0) $display("FAIL read_rxdv: got %b want 0", rxdv); else passed++;
        checks++; if (ifc.rdata !== 8'hA5) $display("FAIL read_rdata_hold: got %h want a5", ifc.rdata); else passed++;
    endtask

    task automatic test_back_to_back;
        int f0, f1, hi_run, lo_after;
        logic ps;
        sel = 1'b0;
        f0 = -1; f1 = -1; hi_run = 0; ps = 1'b1;
        @(negedge clk);
        st = 1'b1; t_rw = 1'b0; t_addr = 7'h21; t_wdata = 8'h44;
        for (int n = 0; n < 600 && f1 < 0; n++) begin
            @(negedge clk);
            if (!m_ssb && ps) begin
                if (f0 < 0) begin
                    f0 = n;
                    t_addr = 7'h22;
                end else begin
                    f1 = n;
                end
            end
            if (m_ssb && f0 >= 0 && f1 < 0) hi_run++;
            ps = m_ssb;
        end
        st = 1'b0;
        checks++; if (f1 - f0 != 141) $display("FAIL b2b_period: got %0d want 141", f1 - f0); else passed++;
        checks++; if (hi_run != 5) $display("FAIL b2b_gap: got %0d want 5", hi_run); else passed++;
        tmo = 1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!m_busy) begin
                tmo = 0;
                break;
            end
        end
        checks++; if (tmo != 0) $display("FAIL b2b_timeout: busy never fell"); else passed++;
        checks++; if (reg_addr !== 7'h22 || rx_d !== 8'h44)
            $display("FAIL b2b_second: got %h/%h want 22/44", reg_addr, rx_d); else passed++;
        frame(1'b0, 7'h6B, 8'h92, 1'b1);
        checks++; if (tsr !== 16'h6B92) $display("FAIL ignored_mosi: got %h want 6b92", tsr); else passed++;
        checks++; if (dn != 1) $display("FAIL ignored_done: got %0d want 1", dn); else passed++;
        lo_after = 0;
        repeat (20) begin
            @(negedge clk);
            if (!m_ssb || m_busy) lo_after++;
        end
        checks++; if (lo_after != 0) $display("FAIL ignored_extra: got %0d active cycles want 0", lo_after); else passed++;
    endtask

    task automatic test_reset_mid;
        int k, dcnt;
        logic pr;
        sel = 1'b0;
        k = 0; pr = 1'b0;
        @(negedge clk);
        st = 1'b1; t_rw = 1'b0; t_addr = 7'h15; t_wdata = 8'h3C;
        @(negedge clk);
        st = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (ifc.SCLK && !pr) k++;
            pr = ifc.SCLK;
            if (k == 6) break;
            @(negedge clk);
        end
        checks++; if (k != 6) $display("FAIL midrst_edge6: got %0d rises want 6", k); else passed++;
        checks++; if (ifc.MOSI !== 1'b1) $display("FAIL midrst_bit6: got %b want 1", ifc.MOSI); else passed++;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++; if (ifc.SSB !== 1'b1 || ifc.SCLK !== 1'b0 || ifc.MOSI !== 1'b0 || ifc.busy !== 1'b0)
            $display("FAIL midrst_outputs: ssb=%b sclk=%b mosi=%b busy=%b want 1/0/0/0",
                     ifc.SSB, ifc.SCLK, ifc.MOSI, ifc.busy); else passed++;
        checks++; if (ifc.rdata !== 8'h00) $display("FAIL midrst_rdata: got %h want 00", ifc.rdata); else passed++;
        dcnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (ifc.done || ifc.rdata_valid) dcnt++;
        end
        checks++; if (dcnt != 0) $display("FAIL midrst_no_done: got %0d pulses want 0", dcnt); else passed++;
        frame(1'b0, 7'h2A, 8'hC3, 1'b0);
        checks++; if (tsr !== 16'h2AC3) $display("FAIL midrst_next_mosi: got %h want 2ac3", tsr); else passed++;
        checks++; if (reg_addr !== 7'h2A || rx_d !== 8'hC3 || rxdv !== 1'b1)
            $display("FAIL midrst_next_target: got %h/%h/%b want 2a/c3/1", reg_addr, rx_d, rxdv); else passed++;
        checks++; if (dn != 1 || ssb_lo != 136)
            $display("FAIL midrst_next_frame: done=%0d ssb_low=%0d want 1/136", dn, ssb_lo); else passed++;
    endtask

    task automatic test_variant;
        sel = 1'b1;
        rd_byte = 8'h5A;
        frame(1'b1, 7'h33, 8'h00, 1'b0);
        checks++; if (tmo != 0) $display("FAIL var_timeout: busy never fell"); else passed++;
        checks++; if (rise1 != 6) $display("FAIL var_first_rise: got %0d want 6", rise1); else passed++;
        checks++; if (half != 8) $display("FAIL var_half: got %0d want 8", half); else passed++;
        checks++; if (ssb_lo != 266) $display("FAIL var_ssb_low: got %0d want 266", ssb_lo); else passed++;
        checks++; if (busy_hi != 270) $display("FAIL var_busy: got %0d want 270", busy_hi); else passed++;
        checks++; if (rd_at !== 8'h5A || rv != 1 || rv_bad != 0)
            $display("FAIL var_read: got %h rdv=%0d bad=%0d want 5a/1/0", rd_at, rv, rv_bad); else passed++;
        checks++; if (tsr !== 16'hB300) $display("FAIL var_mosi: got %h want b300", tsr); else passed++;
        frame(1'b0, 7'h11, 8'hEE, 1'b0);
        checks++; if (ifv.rdata !== 8'h5A) $display("FAIL var_rdata_kept: got %h want 5a", ifv.rdata); else passed++;
        checks++; if (rv != 0 || dn != 1) $display("FAIL var_write_pulses: rdv=%0d done=%0d want 0/1", rv, dn); else passed++;
        checks++; if (rx_d !== 8'hEE || reg_addr !== 7'h11)
            $display("FAIL var_write_target: got %h/%h want 11/ee", reg_addr, rx_d); else passed++;
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_variant();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
